dmux16_router: RTL and testbench

- 16-bit 1-to-2 demultiplexing router: the inverse of the 16-bit 2:1 word mux.
- A single valid/ready input stream is steered by select `s` into one of two buffered output channels, X (`s`=0) or Y (`s`=1).
- Each channel has its own small FIFO, so a stalled consumer on one side does not block traffic to the other side.
- Sits between the datapath word source and two independent word consumers.

---
 rtl/dmux16_router.sv | 139 +++++++++++++
 tb/tb_dmux16_router.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux16_router.sv
// dmux16_router: 16-bit 1-to-2 demultiplexing router.
// A single valid/ready input stream is steered by `s` into one of two
// independently buffered output channels (X for s=0, Y for s=1). Each channel
// owns a DEPTH-entry FIFO, so a stalled consumer only blocks its own side.
// Optional build macro: DMUX16_CNT_EN adds per-channel accepted-word counters
// (x_count / y_count ports).

// Per-channel FIFO: AW-bit wrapping pointers plus an explicit occupancy count
// so that full (count==DEPTH) and empty (count==0) are unambiguous.
module dmux16_chan #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] wdata,
  input  logic        rdy,
  output logic [15:0] rdata,
  output logic        valid,
  output logic        full
);

  logic [DEPTH-1:0][15:0] mem;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   wr;
  logic                   rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = (count != '0);
  assign wr    = push && !full;
  assign rd    = valid && rdy;
  // Head word is forced to zero when empty so idle outputs read as 0.
  assign rdata = valid ? mem[rd_ptr] : 16'h0000;

  // Storage write; contents need no reset because valid masks the output.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; reset flushes the channel in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module dmux16_router #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        s,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] x_data,
  output logic        x_valid,
  input  logic        x_ready,
  output logic [15:0] y_data,
  output logic        y_valid,
  input  logic        y_ready
`ifdef DMUX16_CNT_EN
  ,
  output logic [15:0] x_count,
  output logic [15:0] y_count
`endif
);

  localparam int NCH = 2;

  typedef struct packed {
    logic [15:0] data;
    logic        sel;
  } req_t;

  req_t                  req;
  logic [NCH-1:0]        full;
  logic [NCH-1:0]        valid;
  logic [NCH-1:0]        rdy;
  logic [NCH-1:0]        push;
  logic [NCH-1:0][15:0]  dout;

  assign req = '{data: in_data, sel: s};

  // Readiness depends only on the selected channel's full flag: a full
  // channel refuses even while it drains, and there is no pass-through path.
  assign in_ready = req.sel ? ~full[1] : ~full[0];
  assign rdy      = {y_ready, x_ready};

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign push[c] = in_valid && in_ready && (req.sel == 1'(c));

    dmux16_chan #(.DEPTH(DEPTH), .AW(AW)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .wdata (req.data),
      .rdy   (rdy[c]),
      .rdata (dout[c]),
      .valid (valid[c]),
      .full  (full[c])
    );
  end

  assign x_data  = dout[0];
  assign x_valid = valid[0];
  assign y_data  = dout[1];
  assign y_valid = valid[1];

`ifdef DMUX16_CNT_EN
  // Accepted-word counters; wrap naturally at 16'hFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_count <= '0;
      y_count <= '0;
    end else begin
      if (push[0]) x_count <= x_count + 16'd1;
      if (push[1]) y_count <= y_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmux16_router.sv
// Bench for dmux16_router (DEPTH=2). Expected words are queued when driven;
// a negedge monitor records delivered words and the tests compare them.
module tb_dmux16_router;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_data = '0;
  logic        s = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_ready = 1'b0;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready = 1'b0;
`ifdef DMUX16_CNT_EN
  logic [15:0] x_count;
  logic [15:0] y_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_x[$];
  logic [15:0] exp_y[$];
  logic [15:0] obs_x[0:1023];
  logic [15:0] obs_y[0:1023];
  int wx = 0, wy = 0;
  int rx = 0, ry = 0;

  dmux16_router #(.DEPTH(2), .AW(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
`ifdef DMUX16_CNT_EN
    , .x_count(x_count), .y_count(y_count)
`endif
  );

  always #5 clk = ~clk;

  // Record every word the next rising edge will hand to a consumer.
  always @(negedge clk) begin
    if (!rst) begin
      if (x_valid && x_ready) begin obs_x[wx % 1024] = x_data; wx = wx + 1; end
      if (y_valid && y_ready) begin obs_y[wy % 1024] = y_data; wy = wy + 1; end
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0;
    step; step;
    rst = 1'b0;
    @(negedge clk);
    total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL rst_xvalid got=%b want=0", x_valid); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL rst_yvalid got=%b want=0", y_valid); end
    total++; if (x_data !== 16'h0) begin bad++; $display("FAIL rst_xdata got=%h want=0", x_data); end
    total++; if (y_data !== 16'h0) begin bad++; $display("FAIL rst_ydata got=%h want=0", y_data); end
    s = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_s0 got=%b want=1", in_ready); end
    s = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_s1 got=%b want=1", in_ready); end
    step;
    rx = wx; ry = wy;
    exp_x.delete(); exp_y.delete();
  endtask

  task automatic test_basic;
    logic [15:0] e;
    x_ready = 1'b1; y_ready = 1'b1;
    in_valid = 1'b1; s = 1'b0; in_data = 16'd255; exp_x.push_back(16'd255);
    step;
    s = 1'b1; in_data = 16'd511; exp_y.push_back(16'd511);
    @(negedge clk);
    total++; if (x_valid !== 1'b1 || x_data !== 16'd255) begin bad++; $display("FAIL basic_x got=%b/%0d want=1/255", x_valid, x_data); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL basic_y_idle got=%b want=0", y_valid); end
    step;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (y_valid !== 1'b1 || y_data !== 16'd511) begin bad++; $display("FAIL basic_y got=%b/%0d want=1/511", y_valid, y_data); end
    total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL basic_x_once got=%b want=0", x_valid); end
    repeat (3) step;
    while (exp_x.size() > 0) begin
      e = exp_x.pop_front(); total++;
      if (rx >= wx || obs_x[rx % 1024] !== e) begin bad++; $display("FAIL basic_sbx got=%0d want=%0d", (rx < wx) ? obs_x[rx % 1024] : 16'hxxxx, e); end
      rx++;
    end
    while (exp_y.size() > 0) begin
      e = exp_y.pop_front(); total++;
      if (ry >= wy || obs_y[ry % 1024] !== e) begin bad++; $display("FAIL basic_sby got=%0d want=%0d", (ry < wy) ? obs_y[ry % 1024] : 16'hxxxx, e); end
      ry++;
    end
    total++; if (rx != wx || ry != wy) begin bad++; $display("FAIL basic_extra got=%0d/%0d want=%0d/%0d", wx, wy, rx, ry); end
  endtask

  task automatic test_backpressure;
    logic [15:0] e;
    x_ready = 1'b0; y_ready = 1'b1;
    in_valid = 1'b1; s = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      in_data = 16'(i);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%b want=1", i, in_ready); end
      exp_x.push_back(16'(i));
      step;
    end
    in_data = 16'd3;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
    total++; if (x_valid !== 1'b1 || x_data !== 16'd1) begin bad++; $display("FAIL bp_hold got=%b/%0d want=1/1", x_valid, x_data); end
    #1 s = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_resel got=%b want=1", in_ready); end
    s = 1'b0;
    step;
    s = 1'b1; in_data = 16'd63;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_y_ok got=%b want=1", in_ready); end
    exp_y.push_back(16'd63);
    step;
    s = 1'b0; in_data = 16'd3; x_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_drain got=%b want=0", in_ready); end
    step;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_drain got=%b want=1", in_ready); end
    exp_x.push_back(16'd3);
    step;
    in_valid = 1'b0;
    repeat (4) step;
    while (exp_x.size() > 0) begin
      e = exp_x.pop_front(); total++;
      if (rx >= wx || obs_x[rx % 1024] !== e) begin bad++; $display("FAIL bp_sbx got=%0d want=%0d", (rx < wx) ? obs_x[rx % 1024] : 16'hxxxx, e); end
      rx++;
    end
    while (exp_y.size() > 0) begin
      e = exp_y.pop_front(); total++;
      if (ry >= wy || obs_y[ry % 1024] !== e) begin bad++; $display("FAIL bp_sby got=%0d want=%0d", (ry < wy) ? obs_y[ry % 1024] : 16'hxxxx, e); end
      ry++;
    end
    total++; if (rx != wx || ry != wy) begin bad++; $display("FAIL bp_extra got=%0d/%0d want=%0d/%0d", wx, wy, rx, ry); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e;
    int start;
    x_ready = 1'b0; in_valid = 1'b1; s = 1'b0; in_data = 16'd10;
    exp_x.push_back(16'd10);
    step;
    x_ready = 1'b1;
    start = wx;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'(11 + i);
      exp_x.push_back(16'(11 + i));
      @(negedge clk);
      total++; if (x_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_flow%0d got=%b/%b want=1/1", i, x_valid, in_ready); end
      step;
    end
    in_valid = 1'b0;
    repeat (4) step;
    total++; if (wx - start != 9) begin bad++; $display("FAIL b2b_count got=%0d want=9", wx - start); end
    while (exp_x.size() > 0) begin
      e = exp_x.pop_front(); total++;
      if (rx >= wx || obs_x[rx % 1024] !== e) begin bad++; $display("FAIL b2b_sbx got=%0d want=%0d", (rx < wx) ? obs_x[rx % 1024] : 16'hxxxx, e); end
      rx++;
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] e;
    x_ready = 1'b0; y_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = (i >= 2); in_data = 16'(40 + i);
      step;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (x_valid !== 1'b1 || y_valid !== 1'b1) begin bad++; $display("FAIL mid_filled got=%b/%b want=1/1", x_valid, y_valid); end
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    total++; if (x_valid !== 1'b0 || y_valid !== 1'b0) begin bad++; $display("FAIL mid_flush got=%b/%b want=0/0", x_valid, y_valid); end
    rx = wx; ry = wy;
    in_valid = 1'b1; s = 1'b0; in_data = 16'd100;
    exp_x.push_back(16'd100);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (x_valid !== 1'b1 || x_data !== 16'd100) begin bad++; $display("FAIL mid_after got=%b/%0d want=1/100", x_valid, x_data); end
    step;
    x_ready = 1'b1; y_ready = 1'b1;
    repeat (3) step;
    while (exp_x.size() > 0) begin
      e = exp_x.pop_front(); total++;
      if (rx >= wx || obs_x[rx % 1024] !== e) begin bad++; $display("FAIL mid_sbx got=%0d want=%0d", (rx < wx) ? obs_x[rx % 1024] : 16'hxxxx, e); end
      rx++;
    end
    total++; if (rx != wx || ry != wy) begin bad++; $display("FAIL mid_stale got=%0d/%0d want=%0d/%0d", wx, wy, rx, ry); end
  endtask

`ifdef DMUX16_CNT_EN
  task automatic test_counters;
    x_ready = 1'b1; y_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = (i >= 5); in_data = 16'(i);
      step;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (x_count !== 16'd5 || y_count !== 16'd3) begin bad++; $display("FAIL cnt_values got=%0d/%0d want=5/3", x_count, y_count); end
    step;
    rst = 1'b1; step; rst = 1'b0;
    @(negedge clk);
    total++; if (x_count !== 16'd0 || y_count !== 16'd0) begin bad++; $display("FAIL cnt_clear got=%0d/%0d want=0/0", x_count, y_count); end
    step;
    in_valid = 1'b1; s = 1'b0;
    repeat (65535) step;
    @(negedge clk);
    total++; if (x_count !== 16'hFFFF) begin bad++; $display("FAIL cnt_max got=%h want=ffff", x_count); end
    step;
    @(negedge clk);
    total++; if (x_count !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h want=0000", x_count); end
    in_valid = 1'b0;
    repeat (4) step;
    rx = wx; ry = wy;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
`ifdef DMUX16_CNT_EN
    test_counters;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
